instr_encoder_loader: RTL and testbench

Builds 32-bit instruction words from field-level requests and writes them sequentially into instruction memory. It is the encoding counterpart of the opcode decoder in the single-cycle core. The bench and boot loader use it to place programs in instruction memory without hand-assembled hex. It expands one pseudo-instruction (BLTI) into two machine words.

---
 rtl/instr_encoder_loader.sv | 134 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes field-level instruction requests into 32-bit words and streams them
// into instruction memory, expanding the BLTI pseudo-op into SLTI + BNE.
module instr_encoder_loader #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [5:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic [15:0]   in_imm2,
    input  logic          base_load,
    input  logic [AW-1:0] base_addr,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   word_count,
    output logic          full,
    output logic          err
);

    localparam int          DEPTH_I  = 1 << AW;
    localparam logic [AW:0] DEPTH    = DEPTH_I[AW:0];
    localparam logic [AW:0] DEPTH_M1 = DEPTH - 1'b1;
    localparam logic [3:0]  OP_BLTI  = 4'd12;

    typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} state_t;

    state_t      state, state_nxt;
    logic        accept, reject, start, advance;
    logic        blti_p0;
    logic [31:0] word1_p0;

    function automatic logic [31:0] enc_word0(
        input logic [3:0]  op,
        input logic [4:0]  rs, rt, rd,
        input logic [5:0]  funct,
        input logic [15:0] imm, imm2
    );
        logic [31:0] w;
        case (op)
            4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, funct};
            4'd1:    w = {6'b000010, rs, rt, imm};
            4'd2:    w = {6'b000101, rs, rt, imm};
            4'd3:    w = {6'b000111, rs, rt, imm};
            4'd4:    w = {6'b001000, rs, rt, imm};
            4'd5:    w = {6'b001001, rs, rt, imm};
            4'd6:    w = {6'b010000, rs, rt, imm};
            4'd7:    w = {6'b010001, rs, rt, imm};
            4'd8:    w = {6'b100001, rs, rt, imm};
            4'd9:    w = {6'b100011, rs, rt, imm};
            4'd10:   w = {6'b100000, rs, rt, 16'h0000};
            4'd11:   w = {6'b111000, imm2[9:0], imm};
            4'd12:   w = {6'b000111, rs, 5'd1, imm};   // BLTI: slti $1, rs, imm
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // BLTI second half: bne $1, $0, offset
    function automatic logic [31:0] enc_word1(input logic [15:0] imm2);
        return {6'b100011, 5'd1, 5'd0, imm2};
    endfunction

    assign in_ready = (state == IDLE) & ~full & ~base_load;

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        accept    = in_valid & in_ready;
        reject    = accept & ((in_op > OP_BLTI) |
                              ((in_op == OP_BLTI) & (word_count == DEPTH_M1)));
        start     = accept & ~reject;
        case (state)
            IDLE:    if (start) state_nxt = EMIT0;
            EMIT0: begin
                advance   = 1'b1;
                state_nxt = blti_p0 ? EMIT1 : IDLE;
            end
            EMIT1: begin
                advance   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            blti_p0    <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= reject;
            if ((state == IDLE) && base_load) begin
                imem_we    <= 1'b0;
                imem_addr  <= base_addr;
                word_count <= '0;
                full       <= 1'b0;
            end else if (start) begin
                imem_we    <= 1'b1;
                imem_wdata <= enc_word0(in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_imm2);
                blti_p0    <= (in_op == OP_BLTI);
            end else if (advance) begin
                // word on the bus this cycle is committed; move to the next slot
                imem_addr  <= imem_addr + 1'b1;
                word_count <= word_count + 1'b1;
                full       <= ((word_count + 1'b1) == DEPTH);
                if ((state == EMIT0) && blti_p0) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= word1_p0;
                end else begin
                    imem_we    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) word1_p0 <= enc_word1(in_imm2);
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed plus randomized requests checked
// against a word-list model of the encoder and a write log of the memory bus.
module tb_instr_encoder_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm, in_imm2;
    logic          base_load;
    logic [AW-1:0] base_addr;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic          err;

    instr_encoder_loader #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_imm2(in_imm2),
        .base_load(base_load), .base_addr(base_addr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [39:0] wq[$];
    logic [39:0] eq[$];
    int errs_seen = 0;
    int m_addr = 0, m_cnt = 0, m_errs = 0;
    logic [31:0] last_w0, last_w1;

    // memory-side log of every committed write and every err pulse
    always @(posedge clk) begin
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
        if (err) errs_seen++;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: instruction words from the field layout table
    function automatic void model_words(input int op, rs, rt, rd, funct, imm, imm2,
                                        output int n, output logic [31:0] w0, w1);
        int opc;
        n = 1; w1 = 32'h0;
        case (op)
            1: opc = 2;   2: opc = 5;   3: opc = 7;   4: opc = 8;  5: opc = 9;
            6: opc = 16;  7: opc = 17;  8: opc = 33;  9: opc = 35; 10: opc = 32;
            default: opc = 0;
        endcase
        if (op == 0)
            w0 = 32'(rs) * (2**21) + 32'(rt) * (2**16) + 32'(rd) * (2**11) + 32'(funct);
        else if (op <= 9)
            w0 = 32'(opc) * (2**26) + 32'(rs) * (2**21) + 32'(rt) * (2**16) + 32'(imm);
        else if (op == 10)
            w0 = 32'(opc) * (2**26) + 32'(rs) * (2**21) + 32'(rt) * (2**16);
        else if (op == 11)
            w0 = 32'(56) * (2**26) + 32'(imm2 % 1024) * (2**16) + 32'(imm);
        else if (op == 12) begin
            n  = 2;
            w0 = 32'(7) * (2**26) + 32'(rs) * (2**21) + 32'(1) * (2**16) + 32'(imm);
            w1 = 32'(35) * (2**26) + 32'(1) * (2**21) + 32'(imm2);
        end else begin
            n = 0; w0 = 32'h0;
        end
    endfunction

    task automatic do_req(input int op, rs, rt, rd, funct, imm, imm2);
        int n, guard;
        logic [31:0] w0, w1;
        bit rej;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 40'(in_ready), 40'd1);
            return;
        end
        model_words(op, rs, rt, rd, funct, imm, imm2, n, w0, w1);
        rej = (n == 0) || (n == 2 && m_cnt == DEPTH - 1);
        in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_funct = 6'(funct); in_imm = 16'(imm); in_imm2 = 16'(imm2);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("err_pulse", 40'(err), 40'(rej));
        chk("ready_after_accept", 40'(in_ready), 40'(rej));
        chk("we_word0", 40'(imem_we), 40'(!rej));
        last_w0 = imem_wdata;
        if (!rej) begin
            chk("wdata_word0", 40'(imem_wdata), 40'(w0));
            chk("addr_word0", 40'(imem_addr), 40'(m_addr));
        end
        @(negedge clk);
        chk("err_clear", 40'(err), 40'd0);
        if (n == 2 && !rej) begin
            last_w1 = imem_wdata;
            chk("we_word1", 40'(imem_we), 40'd1);
            chk("wdata_word1", 40'(imem_wdata), 40'(w1));
            chk("addr_word1", 40'(imem_addr), 40'((m_addr + 1) % DEPTH));
            chk("ready_emit1", 40'(in_ready), 40'd0);
            @(negedge clk);
        end
        chk("we_idle", 40'(imem_we), 40'd0);
        if (rej) m_errs++;
        else begin
            eq.push_back({8'(m_addr), w0});
            if (n == 2) eq.push_back({8'((m_addr + 1) % DEPTH), w1});
            m_addr = (m_addr + n) % DEPTH;
            m_cnt  = m_cnt + n;
        end
        chk("count", 40'(word_count), 40'(m_cnt));
        chk("addr_next", 40'(imem_addr), 40'(m_addr));
        chk("full", 40'(full), 40'(m_cnt == DEPTH));
        chk("ready_idle", 40'(in_ready), 40'(m_cnt != DEPTH));
    endtask

    task automatic check_writes();
        chk("write_count", 40'(wq.size()), 40'(eq.size()));
        while (wq.size() > 0 && eq.size() > 0)
            chk("write_log", wq.pop_front(), eq.pop_front());
        wq.delete();
        eq.delete();
        chk("err_total", 40'(errs_seen), 40'(m_errs));
    endtask

    task automatic do_base(input int a);
        @(negedge clk);
        base_load = 1'b1;
        base_addr = 8'(a);
        #1 chk("ready_base_load", 40'(in_ready), 40'd0);
        @(posedge clk);
        #1 base_load = 1'b0;
        m_addr = a; m_cnt = 0;
        @(negedge clk);
        chk("base_count", 40'(word_count), 40'd0);
        chk("base_addr", 40'(imem_addr), 40'(a));
        chk("base_full", 40'(full), 40'd0);
    endtask

    task automatic rand_req(input int op);
        do_req(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 65535));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; base_load = 1'b0; base_addr = '0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0;
        in_imm = '0; in_imm2 = '0;
        #12;
        chk("rst_we", 40'(imem_we), 40'd0);
        chk("rst_addr", 40'(imem_addr), 40'd0);
        chk("rst_wdata", 40'(imem_wdata), 40'd0);
        chk("rst_count", 40'(word_count), 40'd0);
        chk("rst_full", 40'(full), 40'd0);
        chk("rst_err", 40'(err), 40'd0);
        chk("rst_ready", 40'(in_ready), 40'd1);
        @(negedge clk);
        rst = 1'b0;

        do_req(1, 3, 4, 0, 0, 16'h0010, 0);
        chk("addi_const", 40'(last_w0), 40'h08640010);
        do_req(0, 1, 2, 3, 6'h20, 0, 0);
        chk("rtype_const", 40'(last_w0), 40'h00221820);
        do_req(10, 2, 9, 0, 0, 16'h1234, 0);
        chk("move_const", 40'(last_w0), 40'h80490000);
        do_req(12, 5, 0, 0, 0, 7, 16'hFFFE);
        chk("blti_w0_const", 40'(last_w0), 40'h1CA10007);
        chk("blti_w1_const", 40'(last_w1), 40'h8C20FFFE);
        do_req(11, 0, 0, 0, 0, 16'hFFFF, 16'h03FF);
        chk("j_const", 40'(last_w0), 40'hE3FFFFFF);
        do_req(14, 1, 1, 1, 1, 1, 1);
        check_writes();

        for (int i = 0; i < 60; i++) rand_req($urandom_range(0, 15));
        check_writes();

        do_base(8'hFE);
        for (int i = 0; i < 3; i++) rand_req(1);
        chk("wrap_addr", 40'(imem_addr), 40'd1);
        check_writes();

        do_base(0);
        while (m_cnt < DEPTH - 1) rand_req($urandom_range(0, 11));
        rand_req(12);
        chk("blti_at_255_count", 40'(word_count), 40'(DEPTH - 1));
        rand_req(1);
        chk("full_set", 40'(full), 40'd1);
        chk("full_ready", 40'(in_ready), 40'd0);
        in_valid = 1'b1; in_op = 4'd1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("full_no_write_count", 40'(word_count), 40'(DEPTH));
        check_writes();

        do_base(8'h40);
        begin
            int n;
            logic [31:0] w0, w1;
            model_words(12, 7, 0, 0, 0, 16'h0055, 16'h0100, n, w0, w1);
            in_op = 4'd12; in_rs = 5'd7; in_imm = 16'h0055; in_imm2 = 16'h0100;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk("rst_mid_we", 40'(imem_we), 40'd0);
            chk("rst_mid_count", 40'(word_count), 40'd0);
            chk("rst_mid_addr", 40'(imem_addr), 40'd0);
            chk("rst_mid_ready", 40'(in_ready), 40'd1);
            eq.push_back({8'h40, w0});
            @(negedge clk);
            rst = 1'b0;
            m_addr = 0; m_cnt = 0;
            @(negedge clk);
            check_writes();
        end
        rand_req(2);
        check_writes();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
